// File: rtl/spimaster_tx.sv
// SPI master, mode CKP=0/CKE=0: shifts a word out MSB-first on sdo and
// captures sdi into a receive word, framing each transfer with ss.
module spimaster_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic                  ss,
  output logic [2:0]            state_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ss_q, ss_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap;

  assign wrap = (div_q == DIV_LAST);

  // Handshake: start is sampled only while busy=0; the accepting edge
  // captures data_i and raises busy. start while busy=1 is dropped.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = wrap ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (start) begin
          tx_d    = data_i;
          rx_d    = '0;
          bit_d   = '0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          sdo_d   = data_i[DATA_WIDTH-1];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (wrap) begin
          state_d = S_SHIFT_HI;
          sck_d   = 1'b1;
          sdo_d   = tx_q[DATA_WIDTH-1];
          tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
          bit_d   = bit_q + BIT_W'(1);
        end
      end
      S_SHIFT_HI: begin
        // The slave drove sdi on the sck rise, so it is stable here.
        if (wrap) begin
          state_d = S_SHIFT_LO;
          sck_d   = 1'b0;
          rx_d    = {rx_q[DATA_WIDTH-2:0], sdi};
        end
      end
      S_SHIFT_LO: begin
        if (wrap) begin
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_SHIFT_HI;
            sck_d   = 1'b1;
            sdo_d   = tx_q[DATA_WIDTH-1];
            tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (wrap) begin
          state_d = S_GAP;
          ss_d    = 1'b1;
          done_d  = 1'b1;
          data_d  = rx_q;
          sdo_d   = 1'b0;
        end
      end
      S_GAP: begin
        if (wrap) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          bit_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign data_o  = data_q;
  assign sck     = sck_q;
  assign sdo     = sdo_q;
  assign ss      = ss_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_spimaster_tx.sv
// Directed bench for spimaster_tx: loopback, slave model, CLK_DIV=1,
// ignored start, back-to-back transfers and mid-transfer reset.
module tb_spimaster_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       start;
  logic       sel;
  logic       lb;

  logic       busy0, done0, sck0, sdo0, ss0, sdi0;
  logic [7:0] data_o0;
  logic [2:0] state0;
  logic       busy1, done1, sck1, sdo1, ss1, sdi1;
  logic [7:0] data_o1;
  logic [2:0] state1;
  logic       start0, start1;

  logic       m_busy, m_done, m_sck, m_sdo, m_ss;
  logic [7:0] m_data_o;

  logic [7:0] sl_word, sl_tx, sl_rx;
  logic       slave_sdo;

  int tests, fails;
  int r_ss_low, r_first_rise, r_rise, r_hi_bad, r_lo_bad, r_sdo_bad;
  int r_done_cnt, r_done_n, r_busy_fall;
  logic [7:0] r_bits, r_rx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign sdi0   = lb ? sdo0 : slave_sdo;
  assign sdi1   = sdo1;

  assign m_busy   = sel ? busy1   : busy0;
  assign m_done   = sel ? done1   : done0;
  assign m_sck    = sel ? sck1    : sck0;
  assign m_sdo    = sel ? sdo1    : sdo0;
  assign m_ss     = sel ? ss1     : ss0;
  assign m_data_o = sel ? data_o1 : data_o0;

  spimaster_tx #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .start(start0),
    .busy(busy0), .done(done0), .data_o(data_o0), .sck(sck0),
    .sdo(sdo0), .sdi(sdi0), .ss(ss0), .state_o(state0)
  );

  spimaster_tx #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .start(start1),
    .busy(busy1), .done(done1), .data_o(data_o1), .sck(sck1),
    .sdo(sdo1), .sdi(sdi1), .ss(ss1), .state_o(state1)
  );

  // SPI slave on dut: loads its word when ss falls, drives on sck rise,
  // samples master data on sck fall.
  always @(posedge sck0 or negedge ss0) begin
    if (sck0) begin
      slave_sdo <= sl_tx[7];
      sl_tx     <= {sl_tx[6:0], 1'b0};
    end else begin
      sl_tx     <= sl_word;
      slave_sdo <= 1'b0;
    end
  end

  always @(negedge sck0) sl_rx <= {sl_rx[6:0], sdo0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer on the selected DUT; sample index n counts clk edges
  // after the accepting edge, sampled on the falling clk edge.
  task automatic xfer(input logic s, input logic [7:0] word, input int cdiv, input int restart_at);
    logic prev_sck, prev_sdo;
    int hi_run, lo_run;
    sel = s;
    @(negedge clk);
    data_i = word;
    start  = 1'b1;
    prev_sck = 1'b0; prev_sdo = 1'b0; hi_run = 0; lo_run = 0;
    r_ss_low = 0; r_first_rise = -1; r_rise = 0; r_hi_bad = 0; r_lo_bad = 0;
    r_sdo_bad = 0; r_done_cnt = 0; r_done_n = -1; r_busy_fall = -1;
    r_bits = '0; r_rx = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start  = 1'b0;
        data_i = ~word;
      end
      if (n == restart_at) start = 1'b1;
      else if (n == restart_at + 1) start = 1'b0;
      if (!m_ss) r_ss_low++;
      if (m_sck && !prev_sck) begin
        r_rise++;
        if (r_rise == 1) r_first_rise = n;
        else if (lo_run != cdiv) r_lo_bad++;
        lo_run = 0;
      end
      if (!m_sck && prev_sck) begin
        if (hi_run != cdiv) r_hi_bad++;
        if (m_sdo !== prev_sdo) r_sdo_bad++;
        r_bits = {r_bits[6:0], m_sdo};
        hi_run = 0;
      end
      if (m_sck) hi_run++;
      else lo_run++;
      if (m_done) begin
        r_done_cnt++;
        r_done_n = n;
        r_rx = m_data_o;
      end
      prev_sck = m_sck;
      prev_sdo = m_sdo;
      if (!m_busy) begin
        r_busy_fall = n;
        break;
      end
    end
  endtask

  initial begin
    int ss_hi_run, gap_len, dcnt, quiet_done, quiet_ss;
    logic seen_low;
    logic [7:0] rx_a, rx_b;
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; data_i = '0; sel = 1'b0; lb = 1'b1;
    sl_word = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ss", ss0, 1'b1);
    chk("rst_sck", sck0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_data_o", data_o0, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5, data_i scrambled after acceptance.
    xfer(1'b0, 8'hA5, 4, -1);
    chk("a5_first_rise", r_first_rise, 4);
    chk("a5_sck_pulses", r_rise, 8);
    chk("a5_hi_len_bad", r_hi_bad, 0);
    chk("a5_lo_len_bad", r_lo_bad, 0);
    chk("a5_sdo_unstable", r_sdo_bad, 0);
    chk("a5_sdo_bits", r_bits, 8'hA5);
    chk("a5_ss_low", r_ss_low, 72);
    chk("a5_done_at", r_done_n, 72);
    chk("a5_done_cnt", r_done_cnt, 1);
    chk("a5_data_o", r_rx, 8'hA5);
    chk("a5_busy_fall", r_busy_fall, 76);

    // Slave returns 0x3C while master sends 0xFF.
    lb = 1'b0; sl_word = 8'h3C;
    xfer(1'b0, 8'hFF, 4, -1);
    chk("slv_data_o", r_rx, 8'h3C);
    chk("slv_received", sl_rx, 8'hFF);
    chk("slv_done_at", r_done_n, 72);
    lb = 1'b1;

    // CLK_DIV=1 instance.
    xfer(1'b1, 8'h81, 1, -1);
    chk("d1_ss_low", r_ss_low, 18);
    chk("d1_done_at", r_done_n, 18);
    chk("d1_gap", r_busy_fall - r_done_n, 1);
    chk("d1_first_rise", r_first_rise, 1);
    chk("d1_sck_pulses", r_rise, 8);
    chk("d1_hi_len_bad", r_hi_bad, 0);
    chk("d1_lo_len_bad", r_lo_bad, 0);
    chk("d1_data_o", r_rx, 8'h81);

    // start pulsed while busy is ignored.
    xfer(1'b0, 8'h12, 4, 10);
    chk("ign_done_cnt", r_done_cnt, 1);
    chk("ign_data_o", r_rx, 8'h12);
    quiet_ss = 0;
    repeat (12) begin
      @(negedge clk);
      if (!ss0) quiet_ss++;
    end
    chk("ign_no_restart", quiet_ss, 0);

    // Back-to-back with start held high.
    sel = 1'b0;
    @(negedge clk);
    data_i = 8'h55; start = 1'b1;
    ss_hi_run = 0; gap_len = -1; dcnt = 0; seen_low = 1'b0;
    rx_a = '0; rx_b = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n == 0) data_i = 8'hAA;
      if (ss0) begin
        if (seen_low) ss_hi_run++;
      end else begin
        if (ss_hi_run > 0) gap_len = ss_hi_run;
        seen_low = 1'b1;
        ss_hi_run = 0;
      end
      if (done0) begin
        dcnt++;
        if (dcnt == 1) rx_a = data_o0;
        else rx_b = data_o0;
      end
      if (dcnt == 2) begin
        start = 1'b0;
        break;
      end
    end
    chk("b2b_done_cnt", dcnt, 2);
    chk("b2b_ss_gap", gap_len, 5);
    chk("b2b_first_word", rx_a, 8'h55);
    chk("b2b_second_word", rx_b, 8'hAA);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy0) break;
    end
    chk("b2b_idle", busy0, 1'b0);

    // Asynchronous reset in the middle of SHIFT_HI.
    @(negedge clk);
    data_i = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_sck_high", sck0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss", ss0, 1'b1);
    chk("mid_rst_sck", sck0, 1'b0);
    chk("mid_rst_sdo", sdo0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_done", done0, 1'b0);
    chk("mid_rst_data_o", data_o0, 8'h00);
    chk("mid_rst_state", state0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_done = 0;
    quiet_ss = 0;
    repeat (100) begin
      @(negedge clk);
      if (done0) quiet_done++;
      if (!ss0) quiet_ss++;
    end
    chk("post_rst_no_done", quiet_done, 0);
    chk("post_rst_ss_high", quiet_ss, 0);
    chk("post_rst_data_o", data_o0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
